// File: rtl/ro_count_frame_serializer.sv
// ro_count_frame_serializer: snapshots N ring-oscillator counts and shifts them out as one framed, parity-protected bitstream
module ro_count_frame_serializer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter int SYNC_W = 8,
  parameter logic [63:0] SYNC_WORD = 64'hA5,
  parameter bit MSB_FIRST = 1'b0,
  parameter int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    data_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH*CNT_W-1:0] cnt_flat,
  output logic                    busy,
  output logic                    frame_valid,
  output logic                    frame_done,
  output logic [SEL_W-1:0]        sel,
  output logic                    data_out
);
  localparam int BW = $clog2(CNT_W);
  localparam int SW = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;
  localparam logic [2:0] IDLE = 3'd0, SYNC = 3'd1, DATA = 3'd2, PAR = 3'd3, DONE = 3'd4;
  logic [2:0] state_q, state_d;
  logic [SW-1:0] sidx_q, sidx_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [SEL_W-1:0] ch_q, ch_d, sel_q, sel_d;
  logic [NUM_CH*CNT_W-1:0] snap_q, snap_d;
  logic busy_q, busy_d, done_q, done_d, dout_q, dout_d;
  logic [CNT_W-1:0] word;
  always_comb begin
    state_d = state_q;
    sidx_d = sidx_q;
    bidx_d = bidx_q;
    ch_d = ch_q;
    snap_d = snap_q;
    case (state_q)
      SYNC:
        if (int'(sidx_q) == SYNC_W - 1) begin
          state_d = DATA;
          bidx_d = '0;
          ch_d = '0;
        end else sidx_d = sidx_q + 1'b1;
      DATA: if (int'(bidx_q) == CNT_W - 1) state_d = PAR; else bidx_d = bidx_q + 1'b1;
      PAR:
        if (int'(ch_q) == NUM_CH - 1) state_d = DONE;
        else begin
          state_d = DATA;
          bidx_d = '0;
          ch_d = ch_q + 1'b1;
        end
      default: begin
        state_d = start ? SYNC : IDLE;
        sidx_d = '0;
        snap_d = start ? cnt_flat : snap_q;
      end
    endcase
    // outputs are decoded from the next state so they land registered in the same cycle as it
    word = CNT_W'(snap_d >> (int'(ch_d) * CNT_W));
    busy_d = state_d inside {SYNC, DATA, PAR};
    done_d = state_d == DONE;
    sel_d = (state_d == DATA || state_d == PAR) ? ch_d : '0;
    dout_d = state_d == SYNC ? 1'(SYNC_WORD >> (SYNC_W - 1 - int'(sidx_d))) :
             state_d == DATA ? 1'(word >> (MSB_FIRST ? CNT_W - 1 - int'(bidx_d) : int'(bidx_d))) :
             state_d == PAR  ? ^word : 1'b0;
  end
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sidx_q <= '0;
      bidx_q <= '0;
      ch_q <= '0;
      snap_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sel_q <= '0;
      dout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sidx_q <= sidx_d;
      bidx_q <= bidx_d;
      ch_q <= ch_d;
      snap_q <= snap_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sel_q <= sel_d;
      dout_q <= dout_d;
    end
  end
  assign busy = busy_q;
  assign frame_valid = busy_q;
  assign frame_done = done_q;
  assign sel = sel_q;
  assign data_out = dout_q;
endmodule
